// File: rtl/serial_add_sub_mux.sv
// Bit-serial add/subtract stage feeding one mux-based full-adder cell, LSB first.
// Start/busy/done handshake; result, final carry and signed overflow registered.

module full_adder_using_mux (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    // {A,B} selects the 4:1 mux data inputs; Cin (or its complement) is the data.
    always_comb begin
        Sum  = 1'b0;
        Cout = 1'b0;
        case ({A, B})
            2'b00:   begin Sum = Cin;  Cout = 1'b0; end
            2'b01:   begin Sum = ~Cin; Cout = Cin;  end
            2'b10:   begin Sum = ~Cin; Cout = Cin;  end
            default: begin Sum = Cin;  Cout = 1'b1; end
        endcase
    end
endmodule

module serial_add_sub_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             mode_r, carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout, last;

    full_adder_using_mux u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0] ^ mode_r),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Subtraction runs as a + ~b + 1: the carry register is preloaded with mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            mode_r    <= 1'b0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        mode_r  <= mode;
                        carry_q <= mode;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        carry_out <= fa_cout;
                        // carry_q still holds the carry into the MSB here
                        overflow  <= fa_cout ^ carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = res_sh;

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end
endmodule

// File: tb/tb_serial_add_sub_mux.sv
// Scoreboard bench: WIDTH=8 directed cases plus exhaustive WIDTH=4 sweep.

module tb_serial_add_sub_mux;
    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, mode8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, result8;
    logic       carry8, ovf8, busy8, done8;
    logic       start4 = 1'b0, mode4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, result4;
    logic       carry4, ovf4, busy4, done4;

    int   n_vec = 0, n_err = 0;
    int   dcnt8 = 0;
    exp_t q8[$], q4[$];

    always #5 clk = ~clk;

    serial_add_sub_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .result(result8), .carry_out(carry8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_add_sub_mux #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .result(result4), .carry_out(carry4), .overflow(ovf4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Golden model on plain integers, w-bit operands.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic m, input int w);
        exp_t e;
        int   mask, xi, yi, s;
        mask = (1 << w) - 1;
        xi   = int'(x) & mask;
        yi   = m ? (~int'(y)) & mask : int'(y) & mask;
        s    = xi + yi + int'(m);
        e.r  = 8'(s & mask);
        e.c  = 1'((s >> w) & 1);
        e.v  = (((xi >> (w-1)) & 1) == ((yi >> (w-1)) & 1)) &&
               (((s >> (w-1)) & 1) != ((xi >> (w-1)) & 1));
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            dcnt8++;
            chk("sb8_nonempty", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("res8", result8, e.r);
                chk("cout8", carry8, e.c);
                chk("ovf8", ovf8, e.v);
            end
        end
        if (done4) begin
            chk("sb4_nonempty", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("res4", {4'b0, result4}, e.r);
                chk("cout4", carry4, e.c);
                chk("ovf4", ovf4, e.v);
            end
        end
    end

    // One WIDTH=8 operation; inj pulses start with a=FF during RUN and DONE.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                       input logic [7:0] er, input logic ec, input logic ev, input bit inj);
        int lat, bc;
        bit got;
        exp_t e;
        e.r = er; e.c = ec; e.v = ev;
        q8.push_back(e);
        @(negedge clk);
        a8 = ta; b8 = tb; mode8 = tm; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; bc = busy8 ? 1 : 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk); #1;
            if (inj && k == 3) begin start8 = 1'b1; a8 = 8'hFF; end
            if (inj && k == 4) start8 = 1'b0;
            if (done8) begin got = 1'b1; lat = k; end
            else if (busy8) bc++;
        end
        chk("done_seen", got, 1);
        chk("latency", lat, 8);
        chk("busy_cycles", bc, 8);
        if (inj) begin start8 = 1'b1; a8 = 8'hFF; end
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("done_one_cycle", done8, 0);
        if (inj) chk("ign_done_start", busy8, 0);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tm);
        bit got;
        q4.push_back(model({4'b0, ta}, {4'b0, tb}, tm, 4));
        @(negedge clk);
        a4 = ta; b4 = tb; mode4 = tm; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (done4) got = 1'b1;
        end
        if (!got) chk("done4_seen", got, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result8, 0);
        chk("rst_cout", carry8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        rst = 1'b0;

        op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8(8'h2A, 8'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        d0 = dcnt8;
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", dcnt8 - d0, 1);
        chk("hold_result", result8, 8'h30);

        // Abort mid-operation: rst sampled at the 4th RUN edge.
        d0 = dcnt8;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_result", result8, 0);
        chk("abort_cout", carry8, 0);
        chk("abort_ovf", ovf8, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", dcnt8 - d0, 0);
        op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(4'(x), 4'(y), 1'(m));

        repeat (2) @(posedge clk);
        #1;
        chk("sb8_drained", q8.size(), 0);
        chk("sb4_drained", q4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
